lap_memory: RTL

- Downstream of the stopwatch counter (`count`), on the same tick clock.
- Captures the counter's seven BCD `save` digits as lap records into a circular store, 8 entries deep by default.
- Sends either the live display digits or a browsed lap record to the 4-digit display driver.
- Uses the same mode convention as the counter: mode=1 shows the low four digits, mode=0 shows the high four digits.

---
 rtl/lap_memory.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lap_memory.sv
// Lap record store for the stopwatch: captures BCD snapshots into a
// circular buffer and multiplexes live or browsed digits to the display.
module lap_memory #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lap,
   input  logic          browse,
   input  logic          clear,
   input  logic          on,
   input  logic          mode,
   input  logic [3:0]    live0,
   input  logic [3:0]    live1,
   input  logic [3:0]    live2,
   input  logic [3:0]    live3,
   input  logic [3:0]    save0,
   input  logic [3:0]    save1,
   input  logic [3:0]    save2,
   input  logic [3:0]    save3,
   input  logic [3:0]    save4,
   input  logic [3:0]    save5,
   input  logic [3:0]    save6,
   output logic [3:0]    liczba0,
   output logic [3:0]    liczba1,
   output logic [3:0]    liczba2,
   output logic [3:0]    liczba3,
   output logic [AW:0]   lap_count,
   output logic [AW-1:0] view_idx,
   output logic          viewing
);

   typedef enum logic {
      LIVE,
      VIEW
   } state_t;

   localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
   localparam logic [3:0]  BLANK = 4'd11;

   state_t         state;
   state_t         state_nxt;
   logic           lap_q;
   logic           browse_q;
   logic           lap_rise;
   logic           browse_rise;
   logic           erase;
   logic           cap;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  wr_ptr_nxt;
   logic [AW-1:0]  view_idx_nxt;
   logic [AW-1:0]  rd_base;
   logic [AW-1:0]  rd_idx;
   logic [AW:0]    lap_count_nxt;
   logic [AW:0]    last_idx;
   logic [27:0]    mem [DEPTH];
   logic [27:0]    rec;
   logic [3:0]     disp0;
   logic [3:0]     disp1;
   logic [3:0]     disp2;
   logic [3:0]     disp3;

   assign lap_rise    = lap & ~lap_q;
   assign browse_rise = browse & ~browse_q;
   assign erase       = ~clear & on;
   assign cap         = lap_rise & ~erase;
   assign last_idx    = lap_count - 1'b1;

   // When full, lap_count[AW-1:0] is zero so the oldest entry sits at wr_ptr.
   assign rd_base = wr_ptr - lap_count[AW-1:0];
   assign rd_idx  = rd_base + view_idx;
   assign rec     = mem[rd_idx];

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      lap_count_nxt = lap_count;
      view_idx_nxt  = view_idx;
      if (erase) begin
         state_nxt     = LIVE;
         wr_ptr_nxt    = '0;
         lap_count_nxt = '0;
         view_idx_nxt  = '0;
      end else begin
         if (lap_rise) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (lap_count != FULL) begin
               lap_count_nxt = lap_count + 1'b1;
            end
         end
         if (browse_rise) begin
            unique case (state)
               LIVE: begin
                  if (lap_count != '0) begin
                     state_nxt    = VIEW;
                     view_idx_nxt = '0;
                  end
               end
               VIEW: begin
                  if ({1'b0, view_idx} == last_idx) begin
                     state_nxt    = LIVE;
                     view_idx_nxt = '0;
                  end else begin
                     view_idx_nxt = view_idx + 1'b1;
                  end
               end
               default: state_nxt = LIVE;
            endcase
         end
      end
   end

   always_comb begin
      disp0 = live0;
      disp1 = live1;
      disp2 = live2;
      disp3 = live3;
      if (state == VIEW) begin
         if (mode) begin
            disp0 = rec[3:0];
            disp1 = rec[7:4];
            disp2 = rec[11:8];
            disp3 = rec[15:12];
         end else begin
            disp0 = rec[15:12];
            disp1 = rec[19:16];
            disp2 = rec[23:20];
            disp3 = rec[27:24];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LIVE;
         lap_q     <= 1'b0;
         browse_q  <= 1'b0;
         wr_ptr    <= '0;
         lap_count <= '0;
         view_idx  <= '0;
      end else begin
         state     <= state_nxt;
         lap_q     <= lap;
         browse_q  <= browse;
         wr_ptr    <= wr_ptr_nxt;
         lap_count <= lap_count_nxt;
         view_idx  <= view_idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         liczba0 <= BLANK;
         liczba1 <= BLANK;
         liczba2 <= BLANK;
         liczba3 <= BLANK;
         viewing <= 1'b0;
      end else begin
         liczba0 <= disp0;
         liczba1 <= disp1;
         liczba2 <= disp2;
         liczba3 <= disp3;
         viewing <= (state == VIEW);
      end
   end

   // Storage carries no reset; contents are only reachable through lap_count.
   always_ff @(posedge clk) begin
      if (cap) begin
         mem[wr_ptr] <= {save6, save5, save4, save3, save2, save1, save0};
      end
   end

endmodule
